// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the centisecond stopwatch: state encoding, digit width
// and the bit offsets of the six BCD digits inside the 24-bit time word.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int unsigned BCD_W  = 4;
  localparam int unsigned TIME_W = 24;

  localparam int unsigned CS_LO_OFS = 0;
  localparam int unsigned CS_HI_OFS = 4;
  localparam int unsigned S_LO_OFS  = 8;
  localparam int unsigned S_HI_OFS  = 12;
  localparam int unsigned M_LO_OFS  = 16;
  localparam int unsigned M_HI_OFS  = 20;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the ripple-carry time chain. Counts 0..LIMIT on inc, and
// returns to 0 from LIMIT or from any out-of-range value.
import stopwatch_bcd_pkg::*;

module bcd_digit #(
  parameter logic [BCD_W-1:0] LIMIT = 4'd9
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q >= LIMIT) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss.cc BCD stopwatch driven by a 100 Hz clock-enable tick, with start/stop,
// lap freeze, clear and a one-cycle rollover pulse at MAX_MIN:59.99 -> 00:00.00.
import stopwatch_bcd_pkg::*;

module stopwatch_bcd #(
  parameter int MAX_MIN = 59
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  output logic [TIME_W-1:0] count,
  output logic [TIME_W-1:0] disp,
  output logic              running,
  output logic              lap_active,
  output logic              rollover
);

  localparam logic [BCD_W-1:0] MAX_HI = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MAX_LO = BCD_W'(MAX_MIN % 10);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] lap_q, lap_d;
  logic              rollover_q, rollover_d;

  logic             count_en, clear_cnt, clear_all, min_term, wrap;
  logic             c_cs_lo, c_cs_hi, c_s_lo, c_s_hi, c_m_lo, c_m_hi;
  logic [BCD_W-1:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;

  assign count_en = tick_en && ((state_q == RUN) || (state_q == LAP));

  // Minutes wrap on a combined compare against MAX_MIN; a carry out of m_hi
  // (only reachable at 99) is treated as the same wrap.
  assign min_term  = (m_hi == MAX_HI) && (m_lo == MAX_LO);
  assign wrap      = (c_s_hi && min_term) || c_m_hi;
  assign clear_all = clear_cnt || wrap;

  bcd_digit #(.LIMIT(4'd9)) u_cs_lo (.clock(clock), .rst(rst), .inc(count_en), .clr(clear_all),
                                     .digit(cs_lo), .carry(c_cs_lo));
  bcd_digit #(.LIMIT(4'd9)) u_cs_hi (.clock(clock), .rst(rst), .inc(c_cs_lo), .clr(clear_all),
                                     .digit(cs_hi), .carry(c_cs_hi));
  bcd_digit #(.LIMIT(4'd9)) u_s_lo  (.clock(clock), .rst(rst), .inc(c_cs_hi), .clr(clear_all),
                                     .digit(s_lo), .carry(c_s_lo));
  bcd_digit #(.LIMIT(4'd5)) u_s_hi  (.clock(clock), .rst(rst), .inc(c_s_lo), .clr(clear_all),
                                     .digit(s_hi), .carry(c_s_hi));
  bcd_digit #(.LIMIT(4'd9)) u_m_lo  (.clock(clock), .rst(rst), .inc(c_s_hi), .clr(clear_all),
                                     .digit(m_lo), .carry(c_m_lo));
  bcd_digit #(.LIMIT(4'd9)) u_m_hi  (.clock(clock), .rst(rst), .inc(c_m_lo), .clr(clear_all),
                                     .digit(m_hi), .carry(c_m_hi));

  always_comb begin
    count = '0;
    count[CS_LO_OFS +: BCD_W] = cs_lo;
    count[CS_HI_OFS +: BCD_W] = cs_hi;
    count[S_LO_OFS  +: BCD_W] = s_lo;
    count[S_HI_OFS  +: BCD_W] = s_hi;
    count[M_LO_OFS  +: BCD_W] = m_lo;
    count[M_HI_OFS  +: BCD_W] = m_hi;
  end

  // Highest-priority pulse wins even when the current state ignores it.
  always_comb begin
    state_d    = state_q;
    lap_d      = lap_q;
    clear_cnt  = 1'b0;
    rollover_d = wrap;
    if (clear) begin
      if (state_q == PAUSE) begin
        state_d   = IDLE;
        clear_cnt = 1'b1;
      end
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        LAP:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap) begin
      case (state_q)
        RUN: begin
          state_d = LAP;
          lap_d   = count;
        end
        LAP:     state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lap_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_q      <= lap_d;
      rollover_q <= rollover_d;
    end
  end

  assign disp       = (state_q == LAP) ? lap_q : count;
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign lap_active = (state_q == LAP);
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench: directed vector table, async reset, wrap sequence on a
// short-minute instance, then random commands against a centisecond-count model.
module tb_stopwatch_bcd;

  logic        clock, rst, tick_en, start_stop, lap, clear;
  logic [23:0] count_a, disp_a, count_b, disp_b;
  logic        running_a, lap_active_a, rollover_a;
  logic        running_b, lap_active_b, rollover_b;

  int checks = 0;
  int passes = 0;

  stopwatch_bcd #(.MAX_MIN(59)) dut_a (
    .clock(clock), .rst(rst), .tick_en(tick_en), .start_stop(start_stop),
    .lap(lap), .clear(clear), .count(count_a), .disp(disp_a),
    .running(running_a), .lap_active(lap_active_a), .rollover(rollover_a));

  stopwatch_bcd #(.MAX_MIN(1)) dut_b (
    .clock(clock), .rst(rst), .tick_en(tick_en), .start_stop(start_stop),
    .lap(lap), .clear(clear), .count(count_b), .disp(disp_b),
    .running(running_b), .lap_active(lap_active_b), .rollover(rollover_b));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Reference model: time kept as total centiseconds; states 0 idle, 1 run, 2 lap, 3 pause.
  int m_st[2], m_cs[2], m_lap[2], m_max[2];
  bit m_roll[2];

  function automatic logic [23:0] to_bcd(input int cs);
    int mn, sc, cc;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cs[k] = 0; m_lap[k] = 0; m_roll[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit tk, input bit ss, input bit lp, input bit cl);
    for (int k = 0; k < 2; k++) begin
      int ncs;
      ncs = m_cs[k];
      m_roll[k] = 1'b0;
      if (tk && (m_st[k] == 1 || m_st[k] == 2)) begin
        ncs = m_cs[k] + 1;
        if (ncs == (m_max[k] + 1) * 6000) begin
          ncs = 0;
          m_roll[k] = 1'b1;
        end
      end
      if (cl) begin
        if (m_st[k] == 3) begin m_st[k] = 0; ncs = 0; end
      end else if (ss) begin
        m_st[k] = (m_st[k] == 0 || m_st[k] == 3) ? 1 : 3;
      end else if (lp) begin
        if (m_st[k] == 1) begin m_st[k] = 2; m_lap[k] = m_cs[k]; end
        else if (m_st[k] == 2) m_st[k] = 1;
      end
      m_cs[k] = ncs;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic compare_models();
    chk("a.count", 32'(count_a), 32'(to_bcd(m_cs[0])));
    chk("a.disp", 32'(disp_a), 32'(to_bcd(m_st[0] == 2 ? m_lap[0] : m_cs[0])));
    chk("a.running", 32'(running_a), 32'(m_st[0] == 1 || m_st[0] == 2));
    chk("a.lap_active", 32'(lap_active_a), 32'(m_st[0] == 2));
    chk("a.rollover", 32'(rollover_a), 32'(m_roll[0]));
    chk("b.count", 32'(count_b), 32'(to_bcd(m_cs[1])));
    chk("b.disp", 32'(disp_b), 32'(to_bcd(m_st[1] == 2 ? m_lap[1] : m_cs[1])));
    chk("b.running", 32'(running_b), 32'(m_st[1] == 1 || m_st[1] == 2));
    chk("b.lap_active", 32'(lap_active_b), 32'(m_st[1] == 2));
    chk("b.rollover", 32'(rollover_b), 32'(m_roll[1]));
  endtask

  // Drive one cycle of inputs, clock it, then check both DUTs against the model.
  task automatic step(input bit tk, input bit ss, input bit lp, input bit cl);
    tick_en = tk; start_stop = ss; lap = lp; clear = cl;
    @(posedge clock);
    model_step(tk, ss, lp, cl);
    #1;
    tick_en = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    compare_models();
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, ".count"}, 32'(count_a), 32'h0);
    chk({tag, ".disp"}, 32'(disp_a), 32'h0);
    chk({tag, ".running"}, 32'(running_a), 32'h0);
    chk({tag, ".lap_active"}, 32'(lap_active_a), 32'h0);
    chk({tag, ".rollover"}, 32'(rollover_a), 32'h0);
  endtask

  typedef struct {
    bit          tk, ss, lp, cl;
    int          reps;
    logic [23:0] ec, ed;
    bit          er, el;
  } vec_t;

  vec_t vt[$];

  initial begin
    m_max[0] = 59;
    m_max[1] = 1;
    rst = 1'b1; tick_en = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero_a("reset");
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    compare_models();

    vt.push_back('{0, 1, 0, 0,   1, 24'h000000, 24'h000000, 1, 0});
    vt.push_back('{1, 0, 0, 0, 150, 24'h000150, 24'h000150, 1, 0});
    vt.push_back('{1, 0, 0, 0, 150, 24'h000300, 24'h000300, 1, 0});
    vt.push_back('{0, 1, 0, 0,   1, 24'h000300, 24'h000300, 0, 0});
    vt.push_back('{1, 1, 1, 1,   1, 24'h000000, 24'h000000, 0, 0});
    vt.push_back('{1, 0, 1, 0,   1, 24'h000000, 24'h000000, 0, 0});
    vt.push_back('{0, 1, 0, 0,   1, 24'h000000, 24'h000000, 1, 0});
    vt.push_back('{1, 0, 0, 0,   9, 24'h000009, 24'h000009, 1, 0});
    vt.push_back('{1, 1, 0, 0,   1, 24'h000010, 24'h000010, 0, 0});
    vt.push_back('{1, 1, 0, 0,   1, 24'h000010, 24'h000010, 1, 0});
    vt.push_back('{1, 0, 0, 0,  32, 24'h000042, 24'h000042, 1, 0});
    vt.push_back('{0, 0, 1, 0,   1, 24'h000042, 24'h000042, 1, 1});
    vt.push_back('{1, 0, 0, 0,  30, 24'h000072, 24'h000042, 1, 1});
    vt.push_back('{0, 0, 1, 0,   1, 24'h000072, 24'h000072, 1, 0});
    vt.push_back('{1, 0, 0, 1,   1, 24'h000073, 24'h000073, 1, 0});
    vt.push_back('{1, 0, 0, 0, 482, 24'h000555, 24'h000555, 1, 0});
    vt.push_back('{0, 0, 1, 0,   1, 24'h000555, 24'h000555, 1, 1});

    for (int i = 0; i < vt.size(); i++) begin
      for (int r = 0; r < vt[i].reps; r++) step(vt[i].tk, vt[i].ss, vt[i].lp, vt[i].cl);
      chk($sformatf("vec%0d.count", i), 32'(count_a), 32'(vt[i].ec));
      chk($sformatf("vec%0d.disp", i), 32'(disp_a), 32'(vt[i].ed));
      chk($sformatf("vec%0d.running", i), 32'(running_a), 32'(vt[i].er));
      chk($sformatf("vec%0d.lap_active", i), 32'(lap_active_a), 32'(vt[i].el));
    end

    // Asynchronous reset in the middle of a cycle while in LAP at 00:05.55.
    #3;
    rst = 1'b1;
    #1;
    check_zero_a("async_rst");
    tick_en = 1'b1; start_stop = 1'b1; lap = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check_zero_a("rst_held");
    end
    tick_en = 1'b0; start_stop = 1'b0; lap = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    compare_models();

    // Wrap on the MAX_MIN=1 instance: 01:59.99 -> 00:00.00.
    step(0, 1, 0, 0);
    repeat (11999) step(1, 0, 0, 0);
    chk("wrap.pre_count", 32'(count_b), 32'h015999);
    step(1, 0, 0, 0);
    chk("wrap.count", 32'(count_b), 32'h000000);
    chk("wrap.rollover", 32'(rollover_b), 32'h1);
    chk("wrap.running", 32'(running_b), 32'h1);
    chk("wrap.a_count", 32'(count_a), 32'h020000);
    step(0, 0, 0, 0);
    chk("wrap.rollover_clr", 32'(rollover_b), 32'h0);
    step(1, 0, 0, 0);
    chk("wrap.resume", 32'(count_b), 32'h000001);

    // Random single commands with random ticks.
    for (int n = 0; n < 4000; n++) begin
      int r;
      bit tk;
      tk = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 24);
      step(tk, r == 0, r == 1, r == 2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
